// File: rtl/lcd_bus_arbiter_if.sv
// Bundle of the two byte requesters and the shared HD44780 4-bit pins.
// slave: the arbiter side. master: the requester/LCD-model side.
interface lcd_bus_arbiter_if;
    logic       a_valid;
    logic       a_rs;
    logic [7:0] a_data;
    logic       a_lock;
    logic       a_ready;
    logic       b_valid;
    logic       b_rs;
    logic [7:0] b_data;
    logic       b_lock;
    logic       b_ready;
    logic       lcd_rs;
    logic       lcd_en;
    logic [3:0] lcd_data;
    logic       busy;
    logic       grant_b;

    modport slave (
        input  a_valid, a_rs, a_data, a_lock,
        input  b_valid, b_rs, b_data, b_lock,
        output a_ready, b_ready,
        output lcd_rs, lcd_en, lcd_data, busy, grant_b
    );

    modport master (
        output a_valid, a_rs, a_data, a_lock,
        output b_valid, b_rs, b_data, b_lock,
        input  a_ready, b_ready,
        input  lcd_rs, lcd_en, lcd_data, busy, grant_b
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for one HD44780 4-bit LCD bus. Each accepted byte
// goes out as high nibble then low nibble, each latched by one EN pulse,
// followed by the controller execution delay (long for clear/home).
module lcd_bus_arbiter #(
    parameter int SETUP_CYC      = 5,
    parameter int EN_HIGH_CYC    = 25,
    parameter int NIB_GAP_CYC    = 50,
    parameter int SHORT_WAIT_CYC = 2500,
    parameter int LONG_WAIT_CYC  = 82000
) (
    input  logic               clk,
    input  logic               reset,
    lcd_bus_arbiter_if.slave   bus
);

    function automatic int max5(input int p0, input int p1, input int p2,
                                input int p3, input int p4);
        int m;
        m = p0;
        if (p1 > m) m = p1;
        if (p2 > m) m = p2;
        if (p3 > m) m = p3;
        if (p4 > m) m = p4;
        return m;
    endfunction

    // Counter holds (length - 1) of the longest phase; it never wraps.
    localparam int MAX_CYC = max5(SETUP_CYC, EN_HIGH_CYC, NIB_GAP_CYC,
                                  SHORT_WAIT_CYC, LONG_WAIT_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(NIB_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP_H = 3'd1,
        ST_EN_H    = 3'd2,
        ST_GAP     = 3'd3,
        ST_SETUP_L = 3'd4,
        ST_EN_L    = 3'd5,
        ST_WAIT    = 3'd6
    } state_t;

    // Clear display (0x01) and return home (0x02/0x03) need the long delay.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return (rs == 1'b0) && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic             lock_q, lock_d;        // a lock is held
    logic             lock_b_q, lock_b_d;    // lock owner: 0 = A, 1 = B
    logic             last_b_q, last_b_d;    // last served, also grant_b
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;
    logic [3:0]       lcd_data_q, lcd_data_d;
    logic             busy_q, busy_d;

    logic             sel_a, sel_b;
    logic             is_idle;

    // Arbiter selection: lock owner first, then round-robin, then whoever is valid.
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (lock_q && !lock_b_q) begin
            sel_a = bus.a_valid;
            sel_b = 1'b0;
        end else if (lock_q && lock_b_q) begin
            sel_a = 1'b0;
            sel_b = bus.b_valid;
        end else if (bus.a_valid && bus.b_valid) begin
            sel_a = last_b_q;
            sel_b = !last_b_q;
        end else begin
            sel_a = bus.a_valid;
            sel_b = bus.b_valid;
        end
    end

    assign is_idle     = (state_q == ST_IDLE);
    assign bus.a_ready = is_idle && sel_a;
    assign bus.b_ready = is_idle && sel_b;

    // Next-state, phase counter, capture and lock bookkeeping, registered pin values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rs_d       = rs_q;
        data_d     = data_q;
        long_d     = long_q;
        lock_d     = lock_q;
        lock_b_d   = lock_b_q;
        last_b_d   = last_b_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_en_d   = 1'b0;
        lcd_data_d = lcd_data_q;
        busy_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.a_valid && bus.a_ready) begin
                    state_d  = ST_SETUP_H;
                    cnt_d    = SETUP_LD;
                    rs_d     = bus.a_rs;
                    data_d   = bus.a_data;
                    long_d   = is_long_cmd(bus.a_rs, bus.a_data);
                    lock_d   = bus.a_lock;
                    lock_b_d = 1'b0;
                    last_b_d = 1'b0;
                end else if (bus.b_valid && bus.b_ready) begin
                    state_d  = ST_SETUP_H;
                    cnt_d    = SETUP_LD;
                    rs_d     = bus.b_rs;
                    data_d   = bus.b_data;
                    long_d   = is_long_cmd(bus.b_rs, bus.b_data);
                    lock_d   = bus.b_lock;
                    lock_b_d = 1'b1;
                    last_b_d = 1'b1;
                end else if (lock_q && !(lock_b_q ? bus.b_lock : bus.a_lock)) begin
                    // Owner dropped its lock request while idle.
                    lock_d = 1'b0;
                end else begin
                    lock_d = lock_q;
                end
            end
            ST_SETUP_H: begin
                if (cnt_q == '0) begin
                    state_d = ST_EN_H;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EN_H: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETUP_L;
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETUP_L: begin
                if (cnt_q == '0) begin
                    state_d = ST_EN_L;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EN_L: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = long_q ? LONG_LD : SHORT_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins follow the state being entered so they are registered, glitch-free.
        case (state_d)
            ST_SETUP_H, ST_GAP: lcd_data_d = data_d[7:4];
            ST_EN_H: begin
                lcd_data_d = data_d[7:4];
                lcd_en_d   = 1'b1;
            end
            ST_SETUP_L, ST_WAIT: lcd_data_d = data_d[3:0];
            ST_EN_L: begin
                lcd_data_d = data_d[3:0];
                lcd_en_d   = 1'b1;
            end
            default: lcd_data_d = lcd_data_q;
        endcase

        if (state_d != ST_IDLE) begin
            lcd_rs_d = rs_d;
            busy_d   = 1'b1;
        end else begin
            lcd_rs_d = lcd_rs_q;
            busy_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset; partial bytes are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            long_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_b_q   <= 1'b0;
            last_b_q   <= 1'b1;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            lcd_data_q <= 4'h0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            long_q     <= long_d;
            lock_q     <= lock_d;
            lock_b_q   <= lock_b_d;
            last_b_q   <= last_b_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_en_q   <= lcd_en_d;
            lcd_data_q <= lcd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.lcd_rs   = lcd_rs_q;
    assign bus.lcd_en   = lcd_en_q;
    assign bus.lcd_data = lcd_data_q;
    assign bus.busy     = busy_q;
    assign bus.grant_b  = last_b_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter. The long wait is shortened to keep run
// time small; all other timing uses the 50 MHz defaults.
module tb_lcd_bus_arbiter;

    localparam int LONG_W    = 8200;
    localparam int SHORT_GAP = 2611;          // 5+25+50+5+25 + 2500 + 1
    localparam int LONG_GAP  = 111 + LONG_W;  // 8311

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .SETUP_CYC(5), .EN_HIGH_CYC(25), .NIB_GAP_CYC(50),
        .SHORT_WAIT_CYC(2500), .LONG_WAIT_CYC(LONG_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Edge counter: value after an edge is that edge's number.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state (sampled on the falling clock edge).
    logic       nrs_q [$];
    logic [3:0] nib_q [$];
    int         wid_q [$];
    int         rise_q [$];
    int         bfall_q [$];
    logic       acc_who_q [$];
    logic [7:0] acc_dat_q [$];
    int         acc_edge_q [$];
    int         viol = 0;
    int         overlap = 0;

    initial begin : monitor
        logic       p_en;
        logic       p_rs;
        logic [3:0] p_d;
        logic       p_busy;
        int         hi;
        p_en = 1'b0; p_rs = 1'b0; p_d = 4'h0; p_busy = 1'b0; hi = 0;
        forever begin
            @(negedge clk);
            if (bus.a_ready && bus.b_ready) overlap++;
            if (!reset) begin
                if (bus.a_valid && bus.a_ready) begin
                    acc_who_q.push_back(1'b0); acc_dat_q.push_back(bus.a_data);
                    acc_edge_q.push_back(cyc + 1);
                end else if (bus.b_valid && bus.b_ready) begin
                    acc_who_q.push_back(1'b1); acc_dat_q.push_back(bus.b_data);
                    acc_edge_q.push_back(cyc + 1);
                end
            end
            if (!p_en && bus.lcd_en) rise_q.push_back(cyc);
            if (p_en && bus.lcd_en && (bus.lcd_data !== p_d || bus.lcd_rs !== p_rs)) viol++;
            if (p_en && !bus.lcd_en) begin
                nib_q.push_back(p_d); nrs_q.push_back(p_rs); wid_q.push_back(hi);
            end
            if (bus.lcd_en) hi = p_en ? hi + 1 : 1;
            else hi = 0;
            if (p_busy && !bus.busy) bfall_q.push_back(cyc);
            p_en = bus.lcd_en; p_rs = bus.lcd_rs; p_d = bus.lcd_data; p_busy = bus.busy;
        end
    end

    task automatic clear_mon();
        nib_q.delete(); nrs_q.delete(); wid_q.delete(); rise_q.delete();
        bfall_q.delete(); acc_who_q.delete(); acc_dat_q.delete(); acc_edge_q.delete();
        viol = 0; overlap = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.a_rs = 1'b0; bus.a_data = 8'h00; bus.a_lock = 1'b0;
        bus.b_valid = 1'b0; bus.b_rs = 1'b0; bus.b_data = 8'h00; bus.b_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
    endtask

    // Present a byte and wait (bounded) for its accept edge; valid stays high.
    task automatic offer(input logic who, input logic [7:0] d, input logic rs,
                         input logic lk, input int bound, output logic ok);
        ok = 1'b0;
        if (who) begin
            bus.b_valid = 1'b1; bus.b_data = d; bus.b_rs = rs; bus.b_lock = lk;
        end else begin
            bus.a_valid = 1'b1; bus.a_data = d; bus.a_rs = rs; bus.a_lock = lk;
        end
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (who ? bus.b_ready : bus.a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.a_rs = 1'b0; bus.a_data = 8'h00; bus.a_lock = 1'b0;
        bus.b_valid = 1'b0; bus.b_rs = 1'b0; bus.b_data = 8'h00; bus.b_lock = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.lcd_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", bus.lcd_en); end
        checks++; if (bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs got %b want 0", bus.lcd_rs); end
        checks++; if (bus.lcd_data !== 4'h0) begin errors++; $display("FAIL rst_data got %h want 0", bus.lcd_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.grant_b !== 1'b1) begin errors++; $display("FAIL rst_grant got %b want 1", bus.grant_b); end
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", {bus.a_ready, bus.b_ready}); end
        @(posedge clk); #1 reset = 1'b0;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        @(negedge clk);
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin errors++; $display("FAIL first_tie got %b want 10", {bus.a_ready, bus.b_ready}); end
        #1 bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    endtask

    task automatic test_cmd28();
        logic ok;
        logic [3:0] exp_n [4] = '{4'h2, 4'h8, 4'h0, 4'hC};
        do_reset();
        offer(1'b0, 8'h28, 1'b0, 1'b0, 100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL c28_accept got %b want 1", ok); end
        offer(1'b0, 8'h0C, 1'b0, 1'b0, 5000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL c28_accept2 got %b want 1", ok); end
        bus.a_valid = 1'b0;
        wait_idle(5000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL c28_idle got %b want 1", ok); end
        checks++; if (acc_edge_q.size() !== 2) begin errors++; $display("FAIL c28_nacc got %0d want 2", acc_edge_q.size()); end
        else begin
            checks++; if (acc_edge_q[1] - acc_edge_q[0] !== SHORT_GAP) begin errors++; $display("FAIL c28_gap got %0d want %0d", acc_edge_q[1] - acc_edge_q[0], SHORT_GAP); end
        end
        checks++; if (nib_q.size() !== 4) begin errors++; $display("FAIL c28_nnib got %0d want 4", nib_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (nib_q[i] !== exp_n[i] || nrs_q[i] !== 1'b0 || wid_q[i] !== 25) begin
                    errors++; $display("FAIL c28_nib%0d got %h rs %b w %0d want %h rs 0 w 25", i, nib_q[i], nrs_q[i], wid_q[i], exp_n[i]);
                end
            end
        end
        if (rise_q.size() >= 2 && acc_edge_q.size() >= 1) begin
            checks++; if (rise_q[0] - acc_edge_q[0] !== 5) begin errors++; $display("FAIL c28_rise_h got %0d want 5", rise_q[0] - acc_edge_q[0]); end
            checks++; if (rise_q[1] - acc_edge_q[0] !== 85) begin errors++; $display("FAIL c28_rise_l got %0d want 85", rise_q[1] - acc_edge_q[0]); end
        end else begin
            checks++; errors++; $display("FAIL c28_rises got %0d want >=2", rise_q.size());
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL c28_stable got %0d want 0", viol); end
    endtask

    task automatic test_long_wait();
        logic ok;
        logic [3:0] exp_n [4] = '{4'h0, 4'h1, 4'h0, 4'h6};
        do_reset();
        offer(1'b0, 8'h01, 1'b0, 1'b0, 100, ok);
        offer(1'b0, 8'h06, 1'b0, 1'b0, 20000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL long_accept2 got %b want 1", ok); end
        bus.a_valid = 1'b0;
        wait_idle(5000, ok);
        checks++; if (acc_edge_q.size() !== 2) begin errors++; $display("FAIL long_nacc got %0d want 2", acc_edge_q.size()); end
        else begin
            checks++; if (acc_edge_q[1] - acc_edge_q[0] !== LONG_GAP) begin errors++; $display("FAIL long_gap got %0d want %0d", acc_edge_q[1] - acc_edge_q[0], LONG_GAP); end
        end
        checks++; if (nib_q.size() !== 4) begin errors++; $display("FAIL long_nnib got %0d want 4", nib_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (nib_q[i] !== exp_n[i] || wid_q[i] !== 25) begin
                    errors++; $display("FAIL long_nib%0d got %h w %0d want %h w 25", i, nib_q[i], wid_q[i], exp_n[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic ok;
        int n;
        logic exp_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.a_data = 8'h54; bus.a_rs = 1'b1; bus.a_valid = 1'b1;
        bus.b_data = 8'h58; bus.b_rs = 1'b1; bus.b_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.a_ready || bus.b_ready) n++;
            if (n == 4) begin
                @(posedge clk); #1;
                bus.a_valid = 1'b0; bus.b_valid = 1'b0;
                break;
            end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got %0d want 4", n); end
        wait_idle(5000, ok);
        checks++; if (acc_who_q.size() !== 4) begin errors++; $display("FAIL rr_nacc got %0d want 4", acc_who_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (acc_who_q[i] !== exp_w[i] || acc_dat_q[i] !== (exp_w[i] ? 8'h58 : 8'h54)) begin
                    errors++; $display("FAIL rr_order%0d got who %b dat %h want who %b", i, acc_who_q[i], acc_dat_q[i], exp_w[i]);
                end
            end
        end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL rr_both_ready got %0d want 0", overlap); end
    endtask

    task automatic test_lock();
        logic ok;
        logic [7:0] msg [8] = '{8'h54, 8'h48, 8'h45, 8'h20, 8'h47, 8'h41, 8'h4D, 8'h45};
        do_reset();
        bus.b_data = 8'h58; bus.b_rs = 1'b1; bus.b_lock = 1'b0; bus.b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b0, msg[i], 1'b1, (i < 7) ? 1'b1 : 1'b0, 20000, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lock_accept%0d got %b want 1", i, ok); end
        end
        bus.a_valid = 1'b0;
        offer(1'b1, 8'h58, 1'b1, 1'b0, 20000, ok);
        bus.b_valid = 1'b0;
        wait_idle(5000, ok);
        checks++; if (acc_who_q.size() !== 9) begin errors++; $display("FAIL lock_nacc got %0d want 9", acc_who_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (acc_who_q[i] !== 1'b0 || acc_dat_q[i] !== msg[i]) begin
                    errors++; $display("FAIL lock_acc%0d got who %b dat %h want who 0 dat %h", i, acc_who_q[i], acc_dat_q[i], msg[i]);
                end
            end
            checks++; if (acc_who_q[8] !== 1'b1) begin errors++; $display("FAIL lock_b_last got %b want 1", acc_who_q[8]); end
        end
        checks++; if (nib_q.size() !== 18) begin errors++; $display("FAIL lock_nnib got %0d want 18", nib_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if ({nib_q[2*i], nib_q[2*i+1]} !== msg[i] || nrs_q[2*i] !== 1'b1 || nrs_q[2*i+1] !== 1'b1) begin
                    errors++; $display("FAIL lock_dec%0d got %h%h want %h", i, nib_q[2*i], nib_q[2*i+1], msg[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        do_reset();
        offer(1'b0, 8'h30, 1'b0, 1'b0, 100, ok);
        bus.a_valid = 1'b0;
        repeat (90) @(negedge clk);
        checks++; if (bus.lcd_en !== 1'b1) begin errors++; $display("FAIL mid_in_en_l got %b want 1", bus.lcd_en); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.busy, bus.grant_b} !== 8'b0_0_0000_0_1) begin
            errors++; $display("FAIL mid_reset_vals got en %b rs %b d %h busy %b g %b want 0 0 0 0 1", bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.busy, bus.grant_b);
        end
        repeat (20) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.lcd_en !== 1'b0) begin errors++; $display("FAIL mid_no_resume got busy %b en %b want 0 0", bus.busy, bus.lcd_en); end
        clear_mon();
        offer(1'b0, 8'h20, 1'b0, 1'b0, 100, ok);
        bus.a_valid = 1'b0;
        wait_idle(5000, ok);
        checks++; if (nib_q.size() !== 2) begin errors++; $display("FAIL mid_nnib got %0d want 2", nib_q.size()); end
        else begin
            checks++; if (nib_q[0] !== 4'h2 || nib_q[1] !== 4'h0 || wid_q[0] !== 25 || wid_q[1] !== 25) begin
                errors++; $display("FAIL mid_dec got %h %h w %0d %0d want 2 0 w 25 25", nib_q[0], nib_q[1], wid_q[0], wid_q[1]);
            end
        end
    endtask

    task automatic test_b_alone();
        logic ok;
        do_reset();
        offer(1'b1, 8'h4F, 1'b1, 1'b0, 100, ok);
        bus.b_valid = 1'b0;
        checks++; if (bus.grant_b !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL b_grant got g %b busy %b want 1 1", bus.grant_b, bus.busy); end
        wait_idle(5000, ok);
        checks++; if (acc_who_q.size() !== 1 || bfall_q.size() !== 1) begin
            errors++; $display("FAIL b_counts got acc %0d fall %0d want 1 1", acc_who_q.size(), bfall_q.size());
        end else begin
            checks++; if (acc_who_q[0] !== 1'b1) begin errors++; $display("FAIL b_who got %b want 1", acc_who_q[0]); end
            checks++; if (bfall_q[0] - acc_edge_q[0] !== SHORT_GAP - 1) begin errors++; $display("FAIL b_wait got %0d want %0d", bfall_q[0] - acc_edge_q[0], SHORT_GAP - 1); end
        end
        checks++; if (nib_q.size() !== 2) begin errors++; $display("FAIL b_nnib got %0d want 2", nib_q.size()); end
        else begin
            checks++; if (nib_q[0] !== 4'h4 || nib_q[1] !== 4'hF || nrs_q[0] !== 1'b1 || nrs_q[1] !== 1'b1) begin
                errors++; $display("FAIL b_dec got %h %h rs %b %b want 4 F rs 1 1", nib_q[0], nib_q[1], nrs_q[0], nrs_q[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd28();
        test_long_wait();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_b_alone();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
